// File: rtl/ifetch_resp_buffer_if.sv
// Bundle of the fetch-request, memory-port and consumer signals of ifetch_resp_buffer.
// The buffer uses the master modport; its environment uses the slave modport.
interface ifetch_resp_buffer_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic             req_i;
  logic [31:0]      req_pc_i;
  logic             req_accept_o;
  logic             flush_i;
  logic             mem_i_rd_o;
  logic [31:0]      mem_i_pc_o;
  logic             mem_i_flush_o;
  logic             mem_i_invalidate_o;
  logic             mem_i_accept_i;
  logic             mem_i_valid_i;
  logic             mem_i_error_i;
  logic [63:0]      mem_i_inst_i;
  logic             inst_valid_o;
  logic             inst_ready_i;
  logic [63:0]      inst_data_o;
  logic [31:0]      inst_pc_o;
  logic             inst_error_o;
  logic [PTR_W-1:0] level_o;

  modport master (
    input  req_i, req_pc_i, flush_i, mem_i_accept_i, mem_i_valid_i,
           mem_i_error_i, mem_i_inst_i, inst_ready_i,
    output req_accept_o, mem_i_rd_o, mem_i_pc_o, mem_i_flush_o,
           mem_i_invalidate_o, inst_valid_o, inst_data_o, inst_pc_o,
           inst_error_o, level_o
  );

  modport slave (
    output req_i, req_pc_i, flush_i, mem_i_accept_i, mem_i_valid_i,
           mem_i_error_i, mem_i_inst_i, inst_ready_i,
    input  req_accept_o, mem_i_rd_o, mem_i_pc_o, mem_i_flush_o,
           mem_i_invalidate_o, inst_valid_o, inst_data_o, inst_pc_o,
           inst_error_o, level_o
  );
endinterface

// File: rtl/ifetch_resp_buffer.sv
// Instruction-fetch response ring buffer: reserves a slot per issued fetch, captures
// in-order memory responses, and discards responses belonging to flushed fetches.
module ifetch_resp_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  ifetch_resp_buffer_if.master  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t iss_q, rsp_q, rd_q, drop_q;

  logic [31:0] pc_mem   [DEPTH];
  logic [63:0] data_mem [DEPTH];
  logic        err_mem  [DEPTH];

  ptr_t occ_c, pend_c, drop_sum_c, drop_flush_c;
  logic credit_c, issue_c, accept_c, head_valid_c, pop_c, keep_rsp_c, drop_rsp_c;

  // Credit is derived only from registered pointers, so inst_ready_i never reaches mem_i_rd_o.
  always_comb begin
    pend_c       = iss_q - rsp_q;
    occ_c        = (iss_q - rd_q) + drop_q;
    credit_c     = occ_c < ptr_t'(DEPTH);
    issue_c      = bus.req_i & credit_c & ~bus.flush_i & rst_ni;
    accept_c     = issue_c & bus.mem_i_accept_i;
    head_valid_c = rd_q != rsp_q;
    pop_c        = head_valid_c & bus.inst_ready_i & ~bus.flush_i;
    drop_rsp_c   = bus.mem_i_valid_i & ~bus.flush_i & (drop_q != '0);
    keep_rsp_c   = bus.mem_i_valid_i & ~bus.flush_i & (drop_q == '0) & (pend_c != '0);
    // Every outstanding fetch becomes a drop; a response landing in the flush cycle is one of them.
    drop_sum_c   = drop_q + pend_c;
    drop_flush_c = (bus.mem_i_valid_i && drop_sum_c != '0) ? drop_sum_c - ptr_t'(1) : drop_sum_c;
  end

  assign bus.mem_i_rd_o         = issue_c;
  assign bus.req_accept_o       = accept_c;
  assign bus.mem_i_pc_o         = bus.req_pc_i;
  assign bus.mem_i_flush_o      = bus.flush_i;
  assign bus.mem_i_invalidate_o = 1'b0;
  assign bus.inst_valid_o       = head_valid_c;
  assign bus.inst_pc_o          = pc_mem[rd_q[IDX_W-1:0]];
  assign bus.inst_data_o        = data_mem[rd_q[IDX_W-1:0]];
  assign bus.inst_error_o       = err_mem[rd_q[IDX_W-1:0]];
  assign bus.level_o            = occ_c;

  // Pointer and drop-counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_q  <= '0;
      rsp_q  <= '0;
      rd_q   <= '0;
      drop_q <= '0;
    end else if (bus.flush_i) begin
      drop_q <= drop_flush_c;
      rsp_q  <= iss_q;
      rd_q   <= iss_q;
    end else begin
      if (accept_c)   iss_q  <= iss_q + ptr_t'(1);
      if (keep_rsp_c) rsp_q  <= rsp_q + ptr_t'(1);
      if (drop_rsp_c) drop_q <= drop_q - ptr_t'(1);
      if (pop_c)      rd_q   <= rd_q + ptr_t'(1);
    end
  end

  // Entry storage, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (accept_c) pc_mem[iss_q[IDX_W-1:0]] <= bus.req_pc_i;
    if (keep_rsp_c) begin
      data_mem[rsp_q[IDX_W-1:0]] <= bus.mem_i_inst_i;
      err_mem[rsp_q[IDX_W-1:0]]  <= bus.mem_i_error_i;
    end
  end

  a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.mem_i_valid_i |-> (drop_q != '0 || pend_c != '0));

endmodule

// File: tb/tb_ifetch_resp_buffer.sv
// Bench for ifetch_resp_buffer: table vectors, directed flush/backpressure/reset
// sequences and a randomized run against a queue-based fetch model.
module tb_ifetch_resp_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;

  ifetch_resp_buffer_if #(.DEPTH(DEPTH)) bus ();
  ifetch_resp_buffer #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic dropped;} fetch_t;
  typedef struct {logic [31:0] pc; logic [63:0] data; logic err;} entry_t;
  typedef struct {
    logic req; logic [31:0] pc; logic vld; logic err; logic rdy;
    logic e_rd; logic e_ival; logic [31:0] e_ipc; logic e_ierr; logic [PTR_W-1:0] e_lvl;
  } vec_t;

  fetch_t      out_q[$];   // fetches sent to memory, oldest first
  entry_t      rdy_q[$];   // responses waiting for the consumer
  logic [31:0] mem_q[$];   // memory-side view of accepted fetches
  int          checks = 0;
  int          errors = 0;
  vec_t        vt[11];
  logic [31:0] rnd;
  int          n_acc;

  function automatic logic [63:0] data_of(input logic [31:0] pc);
    return {pc ^ 32'hdead_beef, ~pc};
  endfunction

  function automatic int unsigned model_level();
    return out_q.size() + rdy_q.size();
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic exp_rd;
    exp_rd = bus.req_i && (model_level() < DEPTH) && !bus.flush_i;
    chk("level", 64'(bus.level_o), 64'(model_level()));
    chk("inst_valid", 64'(bus.inst_valid_o), 64'(rdy_q.size() != 0));
    chk("mem_rd", 64'(bus.mem_i_rd_o), 64'(exp_rd));
    chk("req_accept", 64'(bus.req_accept_o), 64'(exp_rd && bus.mem_i_accept_i));
    chk("mem_pc", 64'(bus.mem_i_pc_o), 64'(bus.req_pc_i));
    chk("mem_flush", 64'(bus.mem_i_flush_o), 64'(bus.flush_i));
    chk("mem_inval", 64'(bus.mem_i_invalidate_o), 64'(0));
    if (rdy_q.size() != 0) begin
      chk("inst_pc", 64'(bus.inst_pc_o), 64'(rdy_q[0].pc));
      chk("inst_data", bus.inst_data_o, rdy_q[0].data);
      chk("inst_err", 64'(bus.inst_error_o), 64'(rdy_q[0].err));
    end
  endtask

  // Drives one cycle of inputs (memory answers the oldest fetch if vld) and checks the model.
  task automatic drive(input logic req, input logic [31:0] pc, input logic fl, input logic acc,
                       input logic vld, input logic err, input logic rdy);
    bus.req_i          = req;
    bus.req_pc_i       = pc;
    bus.flush_i        = fl;
    bus.mem_i_accept_i = acc;
    bus.mem_i_valid_i  = vld && (mem_q.size() != 0);
    bus.mem_i_inst_i   = (mem_q.size() != 0) ? data_of(mem_q[0]) : 64'h0;
    bus.mem_i_error_i  = err;
    bus.inst_ready_i   = rdy;
    #1;
    model_check();
  endtask

  // Advances the model by the current inputs, then moves to the next cycle.
  task automatic tick();
    logic   pre_valid, exp_acc;
    fetch_t f;
    pre_valid = rdy_q.size() != 0;
    exp_acc   = bus.req_i && (model_level() < DEPTH) && !bus.flush_i && bus.mem_i_accept_i;
    if (bus.mem_i_valid_i && out_q.size() != 0) begin
      f = out_q.pop_front();
      if (!f.dropped && !bus.flush_i)
        rdy_q.push_back('{pc: f.pc, data: bus.mem_i_inst_i, err: bus.mem_i_error_i});
    end
    if (bus.flush_i) begin
      rdy_q.delete();
      foreach (out_q[i]) out_q[i].dropped = 1'b1;
    end else if (pre_valid && bus.inst_ready_i) begin
      void'(rdy_q.pop_front());
    end
    if (exp_acc) out_q.push_back('{pc: bus.req_pc_i, dropped: 1'b0});
    if (bus.mem_i_valid_i && mem_q.size() != 0) void'(mem_q.pop_front());
    if (bus.mem_i_rd_o && bus.mem_i_accept_i) mem_q.push_back(bus.req_pc_i);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && model_level() != 0; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
    end
    chk("drain_level", 64'(bus.level_o), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_i = 1'b1; bus.req_pc_i = 32'h8000_0000; bus.flush_i = 1'b0;
    bus.mem_i_accept_i = 1'b1; bus.mem_i_valid_i = 1'b0; bus.mem_i_error_i = 1'b0;
    bus.mem_i_inst_i = 64'h0; bus.inst_ready_i = 1'b0;

    // req, pc, vld, err, rdy | rd, inst_valid, inst_pc, inst_err, level
    vt[0]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 3'd0};
    vt[1]  = '{1'b1, 32'h8000_0008, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 3'd1};
    vt[2]  = '{1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 3'd2};
    vt[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0008, 1'b0, 3'd2};
    vt[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0010, 1'b0, 3'd1};
    vt[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 3'd0};
    vt[6]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 3'd0};
    vt[7]  = '{1'b1, 32'h8000_0008, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 3'd1};
    vt[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 3'd2};
    vt[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0008, 1'b1, 3'd1};
    vt[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 3'd0};

    // Reset state with a request already pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd", 64'(bus.mem_i_rd_o), 64'(0));
    chk("rst_accept", 64'(bus.req_accept_o), 64'(0));
    chk("rst_valid", 64'(bus.inst_valid_o), 64'(0));
    chk("rst_level", 64'(bus.level_o), 64'(0));
    rst_n = 1'b1;

    // Stream and error-flag vectors
    foreach (vt[i]) begin
      drive(vt[i].req, vt[i].pc, 1'b0, 1'b1, vt[i].vld, vt[i].err, vt[i].rdy);
      chk("tbl_rd", 64'(bus.mem_i_rd_o), 64'(vt[i].e_rd));
      chk("tbl_accept", 64'(bus.req_accept_o), 64'(vt[i].e_rd));
      chk("tbl_valid", 64'(bus.inst_valid_o), 64'(vt[i].e_ival));
      chk("tbl_level", 64'(bus.level_o), 64'(vt[i].e_lvl));
      if (vt[i].e_ival) begin
        chk("tbl_pc", 64'(bus.inst_pc_o), 64'(vt[i].e_ipc));
        chk("tbl_err", 64'(bus.inst_error_o), 64'(vt[i].e_ierr));
      end
      tick();
    end

    // Backpressure: four slots fill, then a single pop frees exactly one
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h8000_0200 + 32'(i * 8), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (bus.req_accept_o) n_acc++;
      tick();
    end
    chk("bp_accepts", 64'(n_acc), 64'(4));
    drive(1'b1, 32'h8000_0240, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("bp_full_rd", 64'(bus.mem_i_rd_o), 64'(0));
    chk("bp_full_level", 64'(bus.level_o), 64'(4));
    tick();
    drive(1'b1, 32'h8000_0240, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_refill", 64'(bus.req_accept_o), 64'(1));
    tick();
    drain();

    // Flush with two outstanding and one buffered
    drive(1'b1, 32'h8000_0300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h8000_0308, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h8000_0310, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h8000_0318, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fl_rd", 64'(bus.mem_i_rd_o), 64'(0));
    chk("fl_level", 64'(bus.level_o), 64'(3));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("fl_valid", 64'(bus.inst_valid_o), 64'(0));
    chk("fl_drop_level", 64'(bus.level_o), 64'(2));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("fl_valid2", 64'(bus.inst_valid_o), 64'(0));
    chk("fl_drop_level2", 64'(bus.level_o), 64'(1));
    tick();
    drive(1'b1, 32'h8000_0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fl_new_accept", 64'(bus.req_accept_o), 64'(1));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("fl_new_pending", 64'(bus.inst_valid_o), 64'(0));
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fl_new_valid", 64'(bus.inst_valid_o), 64'(1));
    chk("fl_new_pc", 64'(bus.inst_pc_o), 64'(32'h8000_0100));
    chk("fl_new_data", bus.inst_data_o, data_of(32'h8000_0100));
    tick();
    drain();

    // Flush in the same cycle as a response, three outstanding
    drive(1'b1, 32'h8000_0400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h8000_0408, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h8000_0410, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("flv_level", 64'(bus.level_o), 64'(2));
    chk("flv_valid", 64'(bus.inst_valid_o), 64'(0));
    tick();
    drain();

    // Asynchronous reset between clock edges, then a fresh fetch
    drive(1'b1, 32'h8000_0500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h8000_0508, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    bus.mem_i_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.inst_valid_o), 64'(0));
    chk("arst_mem_rd", 64'(bus.mem_i_rd_o), 64'(0));
    chk("arst_level", 64'(bus.level_o), 64'(0));
    out_q.delete();
    rdy_q.delete();
    mem_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("arst_fetch_valid", 64'(bus.inst_valid_o), 64'(1));
    chk("arst_fetch_pc", 64'(bus.inst_pc_o), 64'(32'h8000_0000));
    tick();
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom();
      drive($urandom_range(0, 9) < 7, {rnd[31:3], 3'b000}, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 6);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
